// File: rtl/lisnoc_ring_inject_arbiter_pkg.sv
// Shared ring-stop definitions: flit type encodings, arbiter FSM states and
// flit classification helpers.
package lisnoc_ring_inject_arbiter_pkg;

    localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_LAST    = 2'b10;
    localparam logic [1:0] FLIT_SINGLE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RING_PKT  = 2'd1,
        LOCAL_PKT = 2'd2
    } arb_state_e;

    // HEADER or SINGLE: the only types that may open a packet in IDLE.
    function automatic logic is_pkt_start(input logic [1:0] flit_type);
        return (flit_type == FLIT_HEADER) || (flit_type == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/lisnoc_ring_inject_arbiter.sv
// Packet-granular ring output arbiter: pass-through ring traffic has priority,
// and a starvation counter bounds how long local injection can be held off.
module lisnoc_ring_inject_arbiter
    import lisnoc_ring_inject_arbiter_pkg::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int max_ring_pkts   = 4,
    parameter int cnt_width       = 3,
    localparam int flit_width     = flit_data_width + flit_type_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [flit_width-1:0] ring_in_flit,
    input  logic                  ring_in_valid,
    output logic                  ring_in_ready,
    input  logic [flit_width-1:0] local_in_flit,
    input  logic                  local_in_valid,
    output logic                  local_in_ready,
    output logic [flit_width-1:0] out_flit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_src,
    output logic                  err_proto
);

    localparam logic [cnt_width-1:0] max_cnt = cnt_width'(max_ring_pkts);

    arb_state_e           state, state_next;
    logic [cnt_width-1:0] starve_cnt, starve_cnt_next;
    logic                 err_next;

    logic [1:0] ring_type, local_type, sel_type;
    logic       ring_cand, local_cand;
    logic       grant_ring, grant_local;
    logic       ring_xfer, local_xfer;

    assign ring_type  = ring_in_flit[flit_width-1 -: 2];
    assign local_type = local_in_flit[flit_width-1 -: 2];
    assign ring_cand  = ring_in_valid  && is_pkt_start(ring_type);
    assign local_cand = local_in_valid && is_pkt_start(local_type);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            err_proto  <= 1'b0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
            err_proto  <= err_next;
        end
    end

    always_comb begin
        grant_ring      = 1'b0;
        grant_local     = 1'b0;
        state_next      = state;
        starve_cnt_next = starve_cnt;
        err_next        = err_proto;
        out_valid       = 1'b0;
        out_src         = 1'b0;
        out_flit        = ring_in_flit;
        ring_in_ready   = 1'b0;
        local_in_ready  = 1'b0;
        ring_xfer       = 1'b0;
        local_xfer      = 1'b0;
        sel_type        = ring_type;

        case (state)
            IDLE: begin
                if (local_cand && ((starve_cnt == max_cnt) || !ring_cand))
                    grant_local = 1'b1;
                else if (ring_cand)
                    grant_ring = 1'b1;
            end
            RING_PKT:  grant_ring  = 1'b1;
            LOCAL_PKT: grant_local = 1'b1;
            default:   state_next  = IDLE;
        endcase

        // Handshake outputs are gated by reset so they drop the moment rst falls,
        // not only at the next clock edge.
        if (rst) begin
            if (grant_local) begin
                out_valid      = local_in_valid;
                out_src        = 1'b1;
                out_flit       = local_in_flit;
                local_in_ready = out_ready;
                sel_type       = local_type;
            end else if (grant_ring) begin
                out_valid     = ring_in_valid;
                ring_in_ready = out_ready;
            end
        end

        ring_xfer  = ring_in_valid  && ring_in_ready;
        local_xfer = local_in_valid && local_in_ready;

        if (ring_xfer || local_xfer) begin
            if (state == IDLE) begin
                if (sel_type == FLIT_HEADER)
                    state_next = local_xfer ? LOCAL_PKT : RING_PKT;
            end else if (sel_type == FLIT_LAST) begin
                state_next = IDLE;
            end
        end

        if (local_xfer && is_pkt_start(local_type))
            starve_cnt_next = '0;
        else if (state == IDLE && ring_xfer && is_pkt_start(ring_type) &&
                 local_in_valid && starve_cnt != max_cnt)
            starve_cnt_next = starve_cnt + cnt_width'(1);

        if (state == IDLE &&
            ((ring_in_valid  && !is_pkt_start(ring_type)) ||
             (local_in_valid && !is_pkt_start(local_type))))
            err_next = 1'b1;
    end

endmodule

// File: tb/tb_lisnoc_ring_inject_arbiter.sv
// Directed-vector bench for lisnoc_ring_inject_arbiter (max_ring_pkts = 4).
module tb_lisnoc_ring_inject_arbiter;

    localparam logic [1:0] P = 2'b00, H = 2'b01, L = 2'b10, S = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [33:0] ring_in_flit, local_in_flit, out_flit;
    logic        ring_in_valid, ring_in_ready;
    logic        local_in_valid, local_in_ready;
    logic        out_valid, out_ready, out_src, err_proto;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    lisnoc_ring_inject_arbiter #(
        .flit_data_width(32),
        .flit_type_width(2),
        .max_ring_pkts(4),
        .cnt_width(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ring_in_flit(ring_in_flit),
        .ring_in_valid(ring_in_valid),
        .ring_in_ready(ring_in_ready),
        .local_in_flit(local_in_flit),
        .local_in_valid(local_in_valid),
        .local_in_ready(local_in_ready),
        .out_flit(out_flit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_src(out_src),
        .err_proto(err_proto)
    );

    typedef struct {
        logic [33:0] rf;
        logic        rv;
        logic [33:0] lf;
        logic        lv;
        logic        ordy;
        logic        ov;
        logic        src;
        logic        rr;
        logic        lr;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [33:0] fl(input logic [1:0] t, input int d);
        return {t, 32'(d)};
    endfunction

    task automatic add(input logic [33:0] rf, input logic rv, input logic [33:0] lf,
                       input logic lv, input logic ordy, input logic ov, input logic src,
                       input logic rr, input logic lr, input logic err);
        vec_t v;
        v.rf = rf; v.rv = rv; v.lf = lf; v.lv = lv; v.ordy = ordy;
        v.ov = ov; v.src = src; v.rr = rr; v.lr = lr; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [33:0] rf, input logic rv, input logic [33:0] lf,
                         input logic lv, input logic ordy);
        ring_in_flit = rf; ring_in_valid = rv;
        local_in_flit = lf; local_in_valid = lv; out_ready = ordy;
    endtask

    initial begin
        rst = 1'b0;
        drive(fl(H, 9), 1'b1, fl(H, 8), 1'b1, 1'b1);
        #1;
        chk("rst_out_valid", 34'(out_valid), 34'(0));
        chk("rst_ring_ready", 34'(ring_in_ready), 34'(0));
        chk("rst_local_ready", 34'(local_in_ready), 34'(0));
        chk("rst_out_src", 34'(out_src), 34'(0));
        drive('0, 1'b0, '0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_err", 34'(err_proto), 34'(0));

        //   ring flit     rv  local flit    lv  ordy ov src rr lr err
        // ring-only H,P,L
        add(fl(H, 1),   1, fl(P, 0),   0,  1,   1, 0,  1, 0, 0);
        add(fl(P, 2),   1, fl(P, 0),   0,  1,   1, 0,  1, 0, 0);
        add(fl(L, 3),   1, fl(P, 0),   0,  1,   1, 0,  1, 0, 0);
        // lock: ring packet owns link while ring stalls, local header waits
        add(fl(H, 4),   1, fl(H, 100), 1,  1,   1, 0,  1, 0, 0);
        add(fl(P, 0),   0, fl(H, 100), 1,  1,   0, 0,  1, 0, 0);
        add(fl(P, 0),   0, fl(H, 100), 1,  1,   0, 0,  1, 0, 0);
        add(fl(L, 5),   1, fl(H, 100), 1,  1,   1, 0,  1, 0, 0);
        add(fl(P, 0),   0, fl(H, 100), 1,  1,   1, 1,  0, 1, 0);
        add(fl(H, 6),   1, fl(L, 101), 1,  1,   1, 1,  0, 1, 0);
        // starvation: four ring singles, then local gets the link
        add(fl(S, 10),  1, fl(H, 200), 1,  1,   1, 0,  1, 0, 0);
        add(fl(S, 11),  1, fl(H, 200), 1,  1,   1, 0,  1, 0, 0);
        add(fl(S, 12),  1, fl(H, 200), 1,  1,   1, 0,  1, 0, 0);
        add(fl(S, 13),  1, fl(H, 200), 1,  1,   1, 0,  1, 0, 0);
        add(fl(S, 14),  1, fl(H, 200), 1,  1,   1, 1,  0, 1, 0);
        add(fl(S, 15),  1, fl(L, 201), 1,  1,   1, 1,  0, 1, 0);
        add(fl(S, 15),  1, fl(H, 202), 1,  1,   1, 0,  1, 0, 0);
        // backpressure: nothing moves for 5 cycles, then ring header first
        for (int i = 0; i < 5; i++)
            add(fl(H, 20), 1, fl(H, 300), 1, 0, 1, 0,  0, 0, 0);
        add(fl(H, 20),  1, fl(H, 300), 1,  1,   1, 0,  1, 0, 0);
        add(fl(L, 21),  1, fl(H, 300), 1,  1,   1, 0,  1, 0, 0);
        // protocol error from local payload in IDLE; ring keeps flowing
        add(fl(P, 0),   0, fl(P, 400), 1,  1,   0, 0,  0, 0, 0);
        add(fl(S, 30),  1, fl(P, 400), 1,  1,   1, 0,  1, 0, 1);
        add(fl(S, 31),  1, fl(P, 0),   0,  1,   1, 0,  1, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rf, vecs[i].rv, vecs[i].lf, vecs[i].lv, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d_out_valid", i), 34'(out_valid), 34'(vecs[i].ov));
            chk($sformatf("v%0d_ring_ready", i), 34'(ring_in_ready), 34'(vecs[i].rr));
            chk($sformatf("v%0d_local_ready", i), 34'(local_in_ready), 34'(vecs[i].lr));
            chk($sformatf("v%0d_err", i), 34'(err_proto), 34'(vecs[i].err));
            if (vecs[i].ov) begin
                chk($sformatf("v%0d_out_src", i), 34'(out_src), 34'(vecs[i].src));
                chk($sformatf("v%0d_out_flit", i), out_flit,
                    vecs[i].src ? vecs[i].lf : vecs[i].rf);
            end
            @(posedge clk);
            #1;
        end

        // async reset in the middle of a local packet
        drive(fl(P, 0), 1'b0, fl(H, 500), 1'b1, 1'b1);
        #1 chk("ar_hdr_src", 34'(out_src), 34'(1));
        @(posedge clk);
        #1 drive(fl(H, 40), 1'b1, fl(P, 501), 1'b1, 1'b1);
        #1;
        chk("ar_lock_src", 34'(out_src), 34'(1));
        chk("ar_lock_flit", out_flit, fl(P, 501));
        chk("ar_lock_ring_ready", 34'(ring_in_ready), 34'(0));
        #1 rst = 1'b0;
        #1;
        chk("ar_out_valid", 34'(out_valid), 34'(0));
        chk("ar_ring_ready", 34'(ring_in_ready), 34'(0));
        chk("ar_local_ready", 34'(local_in_ready), 34'(0));
        chk("ar_err_cleared", 34'(err_proto), 34'(0));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_post_err", 34'(err_proto), 34'(0));
        chk("ar_post_out_valid", 34'(out_valid), 34'(1));
        chk("ar_post_out_src", 34'(out_src), 34'(0));
        chk("ar_post_ring_ready", 34'(ring_in_ready), 34'(1));
        chk("ar_post_local_ready", 34'(local_in_ready), 34'(0));
        chk("ar_post_flit", out_flit, fl(H, 40));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lisnoc_ring_inject_arbiter.md
Name: lisnoc_ring_inject_arbiter

Overview:
Packet-granular output arbiter for one unidirectional-ring stop. It shares the single ring output link between pass-through ring traffic and local injection. Wormhole packets are never interleaved. Ring traffic has priority, and a starvation counter bounds how long the local port waits. It sits between the ring-side input/local-side input buffers and the downstream ring link of the ring router.

Parameters:
flit_data_width, 32, payload bits per flit
flit_type_width, 2, flit type bits (MSBs of flit); encodings from lisnoc_def.vh (PAYLOAD 00, HEADER 01, LAST 10, SINGLE 11)
max_ring_pkts, 4, consecutive ring packets allowed to win while local is waiting (0 = local wins whenever valid in IDLE)
cnt_width, 3, width of starvation counter; must hold max_ring_pkts

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
ring_in_flit  input  flit_width  flit from ring input buffer
ring_in_valid  input  1  ring flit valid
ring_in_ready  output  1  ring flit accepted when valid&ready
local_in_flit  input  flit_width  flit from local injection buffer
local_in_valid  input  1  local flit valid
local_in_ready  output  1  local flit accepted when valid&ready
out_flit  output  flit_width  flit to ring link
out_valid  output  1  out flit valid
out_ready  input  1  downstream accepts
out_src  output  1  source of current out flit (0 ring, 1 local); debug
err_proto  output  1  sticky: non-header flit presented at a source in IDLE

Behaviour:
- Registered state: FSM {IDLE, RING_PKT, LOCAL_PKT}, starve_cnt[cnt_width], err_proto. Datapath is combinational: zero-cycle latency from the selected input to out_flit.
- Reset (rst=0, async): state=IDLE, starve_cnt=0, err_proto=0. While rst=0, out_valid, ring_in_ready and local_in_ready are forced 0. out_flit is don't-care and out_src=0.
- Transfer on a port = valid&ready on that port. out_valid = valid of the granted source. The granted source's ready = out_ready. The non-granted source's ready = 0.
- The IDLE arbitration candidate is a source whose valid=1 and whose flit type is HEADER or SINGLE.
  - Local wins if it is a candidate and either (starve_cnt==max_ring_pkts) or the ring is not a candidate.
  - Otherwise the ring wins if it is a candidate.
  - With no candidate: out_valid=0.
- IDLE transitions, evaluated on a transfer:
  - HEADER from ring -> RING_PKT.
  - HEADER from local -> LOCAL_PKT.
  - SINGLE from either source -> stay IDLE.
  - No transfer (out_ready=0) -> stay IDLE. Arbitration is re-evaluated next cycle, and the grant may change before a transfer occurs.
- RING_PKT / LOCAL_PKT: the owning source is locked regardless of the other source or starve_cnt. A LAST transfer -> IDLE. PAYLOAD or HEADER transfers stay in the state. A HEADER arriving inside a packet is passed through unchecked.
- starve_cnt:
  - +1 (saturating at max_ring_pkts) on each ring HEADER/SINGLE transfer in IDLE while local_in_valid=1.
  - Cleared to 0 on any local HEADER/SINGLE transfer.
  - Unchanged otherwise.
- err_proto: set when, in IDLE, a source has valid=1 with type PAYLOAD or LAST. That source is not granted (ready=0) and the flit is not consumed. err_proto is cleared only by reset.
- Simultaneous: ring and local headers valid in the same cycle with starve_cnt<max -> ring wins. When they tie with starve_cnt==max -> local wins.
- Backpressure: out_ready=0 holds everything. State and counter change only on transfers.
- Reset mid-packet returns to IDLE immediately. Upstream/downstream packet recovery is outside this block.

Decomposition:
- Flit type encodings and the flit_width derivation come from the shared lisnoc_def.vh / lisnoc_undef.vh include pair.
- FSM state encoding (IDLE=2'd0, RING_PKT=2'd1, LOCAL_PKT=2'd2) goes in the same shared definitions for reuse by other ring-stop controllers.
- No sub-module is needed. The starvation counter and FSM stay inline.

Test Plan:
- Ring-only traffic: 3-flit ring packet H,P,L with out_ready=1 -> 3 output beats on consecutive cycles, out_src=0, local_in_ready=0 throughout, FSM back to IDLE after L.
- Lock: ring header accepted, then local header valid while ring payload is stalled 2 cycles (ring_in_valid=0) -> out_valid=0, local_in_ready=0 until ring LAST. Local then wins next.
- Starvation: max_ring_pkts=4, local header held valid, ring SINGLE flits continuous -> exactly 4 ring singles pass, 5th grant goes to local, starve_cnt returns to 0.
- Backpressure: out_ready=0 for 5 cycles with both sources valid -> no transfers, starve_cnt and state unchanged. Release -> ring header transfers first (cnt<max).
- Protocol error: local PAYLOAD flit valid in IDLE -> local_in_ready=0, err_proto=1 next edge and remaining 1. Ring traffic still flows.
- Async reset mid LOCAL_PKT: drop rst between clock edges -> out_valid, both readies 0 immediately. After release, state IDLE, err_proto=0, ring header is granted.
